// File: rtl/spi_dc_pkg.sv
`default_nettype none
//==============================================================================
// Module : spi_dc_pkg
// Desc   : State encoding and shared constants for the SPI DC byte engine.
// Rev    : 1.0  initial release
//==============================================================================
package spi_dc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_dc_state_t;

    localparam logic SPI_DC_CMD  = 1'b0;
    localparam logic SPI_DC_DATA = 1'b1;

    localparam int SPI_DC_DEFAULT_DIV = 4;

endpackage
`default_nettype wire

// File: rtl/spi_dc_clk_div.sv
`default_nettype none
//==============================================================================
// Module : spi_dc_clk_div
// Desc   : Loadable 8-bit down-counter; one-cycle tick every reload cycles.
// Rev    : 1.0  initial release
//==============================================================================
module spi_dc_clk_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_en,
    output logic       o_tick
);

    logic [7:0] r_cnt;
    logic [7:0] r_reload;
    logic       w_tick;

    // Load wins over counting so a new word always starts a full period.
    assign w_tick = i_en && (r_cnt == 8'd0) && !i_load;
    assign o_tick = w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 8'd0;
            r_reload <= 8'd0;
        end else if (i_load) begin
            r_cnt    <= i_load_val - 8'd1;
            r_reload <= i_load_val;
        end else if (w_tick) begin
            r_cnt    <= r_reload - 8'd1;
        end else if (i_en) begin
            r_cnt    <= r_cnt - 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_dc_byte_engine.sv
`default_nettype none
//==============================================================================
// Module : spi_dc_byte_engine
// Desc   : Mode-0 SPI transmitter with DC pin; optional SPI_DC_RUNTIME_DIV_EN.
// Rev    : 1.0  initial release
//==============================================================================
module spi_dc_byte_engine
    import spi_dc_pkg::*;
#(
    parameter int CLK_DIV = SPI_DC_DEFAULT_DIV,
    parameter int DATA_W  = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
`ifdef SPI_DC_RUNTIME_DIV_EN
    input  logic [7:0]        clk_div,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_dc,
    input  logic              s_last,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_dc,
    output logic              spi_cs_n,
    output logic              busy
);

    localparam int                   c_bit_w = $clog2(DATA_W) + 1;
    localparam logic [c_bit_w-1:0]   c_bits  = c_bit_w'(DATA_W);
    localparam logic [c_bit_w-1:0]   c_last_bit = c_bit_w'(DATA_W - 1);

    spi_dc_state_t       r_state, w_state_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_mosi, w_mosi_nxt;
    logic                r_dc, w_dc_nxt;
    logic                r_cs_n, w_cs_n_nxt;
    logic                r_last, w_last_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [c_bit_w-1:0]  r_bit_cnt, w_bit_cnt_nxt;

    logic                w_accept;
    logic                w_load;
    logic                w_div_en;
    logic                w_tick;
    logic [7:0]          w_word_div;

`ifdef SPI_DC_RUNTIME_DIV_EN
    assign w_word_div = (clk_div == 8'd0) ? 8'd1 : clk_div;
`else
    assign w_word_div = 8'(CLK_DIV);
`endif

    assign s_ready  = (r_state == IDLE) && !ARESET;
    assign w_accept = s_valid && s_ready;

    spi_dc_clk_div u_clk_div (
        .clk        (ACLK),
        .rst        (ARESET),
        .i_load     (w_load),
        .i_load_val (w_word_div),
        .i_en       (w_div_en),
        .o_tick     (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_dc_nxt      = r_dc;
        w_cs_n_nxt    = r_cs_n;
        w_last_nxt    = r_last;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_load        = 1'b0;
        w_div_en      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nxt   = s_data;
                    w_last_nxt    = s_last;
                    w_dc_nxt      = s_dc;
                    w_cs_n_nxt    = 1'b0;
                    w_sclk_nxt    = 1'b0;
                    w_mosi_nxt    = s_data[DATA_W-1];
                    w_bit_cnt_nxt = '0;
                    w_load        = 1'b1;
                    w_state_nxt   = SETUP;
                end
            end
            SETUP: begin
                w_div_en = 1'b1;
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_div_en = 1'b1;
                if (w_tick) begin
                    if (r_sclk) begin
                        w_sclk_nxt    = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        // The final bit stays on MOSI after the word ends.
                        if (r_bit_cnt != c_last_bit) begin
                            w_mosi_nxt  = r_shift[DATA_W-2];
                            w_shift_nxt = r_shift << 1;
                        end
                    end else if (r_bit_cnt == c_bits) begin
                        w_state_nxt = r_last ? HOLD : IDLE;
                    end else begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                w_div_en = 1'b1;
                if (w_tick) begin
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_dc      <= SPI_DC_CMD;
            r_cs_n    <= 1'b1;
            r_last    <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_dc      <= w_dc_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_last    <= w_last_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_dc   = r_dc;
    assign spi_cs_n = r_cs_n;
    assign busy     = (r_state != IDLE) || !r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_dc_byte_engine.sv
`default_nettype none
//==============================================================================
// Module : tb_spi_dc_byte_engine
// Desc   : Directed bench for spi_dc_byte_engine at CLK_DIV=2 and CLK_DIV=1.
// Rev    : 1.0  initial release
//==============================================================================
module tb_spi_dc_byte_engine;
    import spi_dc_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       s_valid, s_dc, s_last, sel;
    logic [7:0] s_data;
    logic       valid_2, ready_2, sclk_2, mosi_2, dc_2, cs_n_2, busy_2;
    logic       valid_1, ready_1, sclk_1, mosi_1, dc_1, cs_n_1, busy_1;
    logic       m_ready, m_sclk, m_mosi, m_dc, m_cs_n, m_busy;

    always #5 ACLK = ~ACLK;

    assign valid_2 = s_valid && !sel;
    assign valid_1 = s_valid && sel;
    assign m_ready = sel ? ready_1 : ready_2;
    assign m_sclk  = sel ? sclk_1  : sclk_2;
    assign m_mosi  = sel ? mosi_1  : mosi_2;
    assign m_dc    = sel ? dc_1    : dc_2;
    assign m_cs_n  = sel ? cs_n_1  : cs_n_2;
    assign m_busy  = sel ? busy_1  : busy_2;

    spi_dc_byte_engine #(.CLK_DIV(2), .DATA_W(8)) u_dut2 (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
`ifdef SPI_DC_RUNTIME_DIV_EN
        .clk_div  (8'd2),
`endif
        .s_valid  (valid_2),
        .s_ready  (ready_2),
        .s_data   (s_data),
        .s_dc     (s_dc),
        .s_last   (s_last),
        .spi_sclk (sclk_2),
        .spi_mosi (mosi_2),
        .spi_dc   (dc_2),
        .spi_cs_n (cs_n_2),
        .busy     (busy_2)
    );

    spi_dc_byte_engine #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
`ifdef SPI_DC_RUNTIME_DIV_EN
        .clk_div  (8'd1),
`endif
        .s_valid  (valid_1),
        .s_ready  (ready_1),
        .s_data   (s_data),
        .s_dc     (s_dc),
        .s_last   (s_last),
        .spi_sclk (sclk_1),
        .spi_mosi (mosi_1),
        .spi_dc   (dc_1),
        .spi_cs_n (cs_n_1),
        .busy     (busy_1)
    );

    int          n_vec  = 0;
    int          n_fail = 0;

    logic [7:0]  wd  [0:3];
    logic        wdc [0:3];
    logic        wl  [0:3];
    int          acc_k [0:3];

    logic        c_sclk [0:127];
    logic        c_mosi [0:127];
    logic        c_cs   [0:127];
    logic        c_dc   [0:127];
    logic        c_busy [0:127];
    logic        c_ready[0:127];

    int          n_rise, cs_low, cs_rise, first_rise, second_rise, dc_bad, n_rdy;
    logic [31:0] pat, dcpat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic sample(input int k);
        c_sclk[k]  = m_sclk;
        c_mosi[k]  = m_mosi;
        c_cs[k]    = m_cs_n;
        c_dc[k]    = m_dc;
        c_busy[k]  = m_busy;
        c_ready[k] = m_ready;
    endtask

    // Presents words in order, advancing only on a completed handshake.
    // Sample 0 is the pre-run state; sample k follows the k-th clock edge.
    task automatic run(input int nw, input int ncyc);
        int   idx;
        logic acc;
        idx = 0;
        for (int i = 0; i < 4; i++) acc_k[i] = -1;
        sample(0);
        for (int k = 1; k <= ncyc; k++) begin
            if (idx < nw) begin
                s_valid = 1'b1;
                s_data  = wd[idx];
                s_dc    = wdc[idx];
                s_last  = wl[idx];
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && m_ready;
            step();
            if (acc) begin
                acc_k[idx] = k - 1;
                idx++;
            end
            sample(k);
        end
        s_valid = 1'b0;
    endtask

    task automatic analyze(input int ncyc);
        n_rise = 0; cs_low = 0; cs_rise = 0; dc_bad = 0;
        first_rise = -1; second_rise = -1;
        pat = '0; dcpat = '0;
        for (int k = 1; k <= ncyc; k++) begin
            if (!c_cs[k]) cs_low++;
            if (c_cs[k] && !c_cs[k-1]) cs_rise++;
            if (c_sclk[k] && !c_sclk[k-1]) begin
                n_rise++;
                pat   = {pat[30:0], c_mosi[k]};
                dcpat = {dcpat[30:0], c_dc[k]};
                if (first_rise < 0) first_rise = k;
                else if (second_rise < 0) second_rise = k;
            end
            if ((c_dc[k] !== c_dc[k-1]) && (c_sclk[k] || c_sclk[k-1] || c_cs[k])) dc_bad++;
        end
    endtask

    initial begin
        sel = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_dc = 1'b0; s_last = 1'b0;
        ARESET = 1'b1;
        step(); step();
        chk("rst_cs_n",   cs_n_2,  1'b1);
        chk("rst_sclk",   sclk_2,  1'b0);
        chk("rst_mosi",   mosi_2,  1'b0);
        chk("rst_dc",     dc_2,    1'b0);
        chk("rst_ready",  ready_2, 1'b0);
        chk("rst_busy",   busy_2,  1'b0);
        chk("rst_cs_n_1", cs_n_1,  1'b1);
        chk("rst_ready_1", ready_1, 1'b0);
        ARESET = 1'b0;
        step();
        chk("ready_after_rst", ready_2, 1'b1);

        // Single command 0x2A, last, CLK_DIV=2
        wd[0] = 8'h2A; wdc[0] = SPI_DC_CMD; wl[0] = 1'b1;
        run(1, 42);
        analyze(42);
        chk("t1_ready_idle", c_ready[0], 1'b1);
        chk("t1_cs_fall",    c_cs[1], 1'b0);
        chk("t1_first_rise", first_rise, 3);
        chk("t1_rises",      n_rise, 8);
        chk("t1_mosi",       pat, 32'h2A);
        chk("t1_dc",         dcpat, 32'h0);
        chk("t1_cs_low",     cs_low, 36);
        chk("t1_cs_hold",    c_cs[36], 1'b0);
        chk("t1_cs_rise",    c_cs[37], 1'b1);
        chk("t1_busy_hold",  c_busy[36], 1'b1);
        chk("t1_busy_fall",  c_busy[37], 1'b0);
        chk("t1_mosi_idle",  c_mosi[37], 1'b0);
        chk("t1_dc_glitch",  dc_bad, 0);

        // Three-word frame, DC switches to data on the second word
        wd[0] = 8'h2C; wdc[0] = SPI_DC_CMD;  wl[0] = 1'b0;
        wd[1] = 8'hF8; wdc[1] = SPI_DC_DATA; wl[1] = 1'b0;
        wd[2] = 8'h00; wdc[2] = SPI_DC_DATA; wl[2] = 1'b1;
        run(3, 115);
        analyze(115);
        chk("fr_acc1",    acc_k[1], 35);
        chk("fr_acc2",    acc_k[2], 70);
        chk("fr_rises",   n_rise, 24);
        chk("fr_mosi",    pat, 32'h002CF800);
        chk("fr_dc",      dcpat, 32'h0000FFFF);
        chk("fr_cs_low",  cs_low, 106);
        chk("fr_cs_rise", cs_rise, 1);
        chk("fr_cs_end",  c_cs[107], 1'b1);
        chk("fr_dc_glitch", dc_bad, 0);

        // Second word held valid while the first is still shifting
        wd[0] = 8'h2A; wdc[0] = SPI_DC_CMD;  wl[0] = 1'b1;
        wd[1] = 8'hFF; wdc[1] = SPI_DC_DATA; wl[1] = 1'b1;
        run(2, 80);
        analyze(80);
        n_rdy = 0;
        for (int k = 1; k <= 36; k++) if (c_ready[k]) n_rdy++;
        chk("hs_ready_low", n_rdy, 0);
        chk("hs_acc1",      acc_k[1], 37);
        chk("hs_rises",     n_rise, 16);
        chk("hs_mosi",      pat, 32'h00002AFF);
        chk("hs_cs_rise",   cs_rise, 2);

        // Reset after the fourth bit has shifted out
        wd[0] = 8'hAD; wdc[0] = SPI_DC_DATA; wl[0] = 1'b1;
        run(1, 18);
        analyze(18);
        chk("mr_rises_pre", n_rise, 4);
        chk("mr_mosi_pre",  c_mosi[18], 1'b1);
        chk("mr_cs_pre",    c_cs[18], 1'b0);
        ARESET = 1'b1;
        step();
        chk("mr_cs_n",  cs_n_2,  1'b1);
        chk("mr_sclk",  sclk_2,  1'b0);
        chk("mr_mosi",  mosi_2,  1'b0);
        chk("mr_ready", ready_2, 1'b0);
        chk("mr_busy",  busy_2,  1'b0);
        ARESET = 1'b0;
        step();
        wd[0] = 8'h3C; wdc[0] = SPI_DC_DATA; wl[0] = 1'b1;
        run(1, 42);
        analyze(42);
        chk("mr_post_mosi",  pat, 32'h3C);
        chk("mr_post_first", first_rise, 3);
        chk("mr_post_cslow", cs_low, 36);

        // CLK_DIV=1 instance, 0xA5
        sel = 1'b1;
        wd[0] = 8'hA5; wdc[0] = SPI_DC_CMD; wl[0] = 1'b1;
        run(1, 24);
        analyze(24);
        chk("d1_first_rise", first_rise, 2);
        chk("d1_period",     second_rise - first_rise, 2);
        chk("d1_rises",      n_rise, 8);
        chk("d1_mosi",       pat, 32'hA5);
        chk("d1_cs_low",     cs_low, 18);
        chk("d1_mosi_hold",  c_mosi[18], 1'b1);
        chk("d1_mosi_idle",  c_mosi[19], 1'b0);
        chk("d1_cs_rise",    c_cs[19], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
